// File: rtl/regs_id_ex_if.sv
// Decode-to-execute bundle: freeze/flush controls, decoded inputs, registered outputs.
// The decode/hazard side is the master; the pipeline register is the slave.
interface regs_id_ex_if #(
    parameter int COUNT_W = 16
);
    logic               freeze;
    logic               flush;

    logic [31:0]        pcIn;
    logic [3:0]         aluCmdIn;
    logic               memReadIn;
    logic               memWriteIn;
    logic               wbEnIn;
    logic               branchIn;
    logic               sIn;
    logic [31:0]        valRnIn;
    logic [31:0]        valRmIn;
    logic               immIn;
    logic [11:0]        shiftOperandIn;
    logic [23:0]        imm24In;
    logic [3:0]         destIn;
    logic [3:0]         src1In;
    logic [3:0]         src2In;
    logic               carryIn;

    logic [31:0]        pcOut;
    logic [3:0]         aluCmdOut;
    logic               memReadOut;
    logic               memWriteOut;
    logic               wbEnOut;
    logic               branchOut;
    logic               sOut;
    logic [31:0]        valRnOut;
    logic [31:0]        valRmOut;
    logic               immOut;
    logic [11:0]        shiftOperandOut;
    logic [23:0]        imm24Out;
    logic [3:0]         destOut;
    logic [3:0]         src1Out;
    logic [3:0]         src2Out;
    logic               carryOut;
    logic               validOut;
    logic [COUNT_W-1:0] bubbleCount;

    modport master (
        output freeze, flush,
        output pcIn, aluCmdIn, memReadIn, memWriteIn, wbEnIn, branchIn, sIn,
        output valRnIn, valRmIn, immIn, shiftOperandIn, imm24In,
        output destIn, src1In, src2In, carryIn,
        input  pcOut, aluCmdOut, memReadOut, memWriteOut, wbEnOut, branchOut, sOut,
        input  valRnOut, valRmOut, immOut, shiftOperandOut, imm24Out,
        input  destOut, src1Out, src2Out, carryOut, validOut, bubbleCount
    );

    modport slave (
        input  freeze, flush,
        input  pcIn, aluCmdIn, memReadIn, memWriteIn, wbEnIn, branchIn, sIn,
        input  valRnIn, valRmIn, immIn, shiftOperandIn, imm24In,
        input  destIn, src1In, src2In, carryIn,
        output pcOut, aluCmdOut, memReadOut, memWriteOut, wbEnOut, branchOut, sOut,
        output valRnOut, valRmOut, immOut, shiftOperandOut, imm24Out,
        output destOut, src1Out, src2Out, carryOut, validOut, bubbleCount
    );
endinterface

// File: rtl/regs_id_ex.sv
// ID/EX pipeline register with freeze (hold), flush (bubble insert), valid flag
// and a saturating count of flush-inserted bubbles.
module regs_id_ex #(
    parameter int COUNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    regs_id_ex_if.slave  bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  aluCmd;
        logic        memRead;
        logic        memWrite;
        logic        wbEn;
        logic        branch;
        logic        s;
        logic [31:0] valRn;
        logic [31:0] valRm;
        logic        imm;
        logic [11:0] shiftOperand;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        carry;
    } entry_t;

    entry_t             entryIn;
    entry_t             entryQ;
    logic               validQ;
    logic [COUNT_W-1:0] countQ;

    assign entryIn = '{
        pc:           bus.pcIn,
        aluCmd:       bus.aluCmdIn,
        memRead:      bus.memReadIn,
        memWrite:     bus.memWriteIn,
        wbEn:         bus.wbEnIn,
        branch:       bus.branchIn,
        s:            bus.sIn,
        valRn:        bus.valRnIn,
        valRm:        bus.valRmIn,
        imm:          bus.immIn,
        shiftOperand: bus.shiftOperandIn,
        imm24:        bus.imm24In,
        dest:         bus.destIn,
        src1:         bus.src1In,
        src2:         bus.src2In,
        carry:        bus.carryIn
    };

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entryQ <= '0;
            validQ <= 1'b0;
            countQ <= '0;
        end else if (!bus.freeze) begin
            if (bus.flush) begin
                // Datapath is zeroed too, so forwarding never matches stale indices.
                entryQ <= '0;
                validQ <= 1'b0;
                if (countQ != {COUNT_W{1'b1}}) begin
                    countQ <= countQ + COUNT_W'(1);
                end
            end else begin
                entryQ <= entryIn;
                validQ <= 1'b1;
            end
        end
    end

    assign bus.pcOut           = entryQ.pc;
    assign bus.aluCmdOut       = entryQ.aluCmd;
    assign bus.memReadOut      = entryQ.memRead;
    assign bus.memWriteOut     = entryQ.memWrite;
    assign bus.wbEnOut         = entryQ.wbEn;
    assign bus.branchOut       = entryQ.branch;
    assign bus.sOut            = entryQ.s;
    assign bus.valRnOut        = entryQ.valRn;
    assign bus.valRmOut        = entryQ.valRm;
    assign bus.immOut          = entryQ.imm;
    assign bus.shiftOperandOut = entryQ.shiftOperand;
    assign bus.imm24Out        = entryQ.imm24;
    assign bus.destOut         = entryQ.dest;
    assign bus.src1Out         = entryQ.src1;
    assign bus.src2Out         = entryQ.src2;
    assign bus.carryOut        = entryQ.carry;
    assign bus.validOut        = validQ;
    assign bus.bubbleCount     = countQ;

endmodule

// File: tb/tb_regs_id_ex.sv
// Scoreboard bench for regs_id_ex: a behavioural model pushes the expected
// output set per edge; each test pops it after the edge and compares.
module tb_regs_id_ex;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  aluCmd;
        logic        memRead;
        logic        memWrite;
        logic        wbEn;
        logic        branch;
        logic        s;
        logic [31:0] valRn;
        logic [31:0] valRm;
        logic        imm;
        logic [11:0] shiftOperand;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        carry;
        logic        valid;
        logic [15:0] count;
    } obs_t;

    logic clk;
    logic rst;

    regs_id_ex_if #(.COUNT_W(16)) bus ();
    regs_id_ex_if #(.COUNT_W(2))  bus2 ();

    regs_id_ex #(.COUNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    regs_id_ex #(.COUNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int   checks   = 0;
    int   failures = 0;
    obs_t model;
    obs_t expQ[$];
    logic [1:0] satQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sampleDut();
        obs_t o;
        o.pc           = bus.pcOut;
        o.aluCmd       = bus.aluCmdOut;
        o.memRead      = bus.memReadOut;
        o.memWrite     = bus.memWriteOut;
        o.wbEn         = bus.wbEnOut;
        o.branch       = bus.branchOut;
        o.s            = bus.sOut;
        o.valRn        = bus.valRnOut;
        o.valRm        = bus.valRmOut;
        o.imm          = bus.immOut;
        o.shiftOperand = bus.shiftOperandOut;
        o.imm24        = bus.imm24Out;
        o.dest         = bus.destOut;
        o.src1         = bus.src1Out;
        o.src2         = bus.src2Out;
        o.carry        = bus.carryOut;
        o.valid        = bus.validOut;
        o.count        = bus.bubbleCount;
        return o;
    endfunction

    function automatic obs_t inputsAsObs();
        obs_t o;
        o.pc           = bus.pcIn;
        o.aluCmd       = bus.aluCmdIn;
        o.memRead      = bus.memReadIn;
        o.memWrite     = bus.memWriteIn;
        o.wbEn         = bus.wbEnIn;
        o.branch       = bus.branchIn;
        o.s            = bus.sIn;
        o.valRn        = bus.valRnIn;
        o.valRm        = bus.valRmIn;
        o.imm          = bus.immIn;
        o.shiftOperand = bus.shiftOperandIn;
        o.imm24        = bus.imm24In;
        o.dest         = bus.destIn;
        o.src1         = bus.src1In;
        o.src2         = bus.src2In;
        o.carry        = bus.carryIn;
        o.valid        = 1'b1;
        o.count        = model.count;
        return o;
    endfunction

    task automatic randomInputs();
        bus.pcIn           = $urandom();
        bus.aluCmdIn       = 4'($urandom());
        bus.memReadIn      = 1'($urandom());
        bus.memWriteIn     = 1'($urandom());
        bus.wbEnIn         = 1'($urandom());
        bus.branchIn       = 1'($urandom());
        bus.sIn            = 1'($urandom());
        bus.valRnIn        = $urandom();
        bus.valRmIn        = $urandom();
        bus.immIn          = 1'($urandom());
        bus.shiftOperandIn = 12'($urandom());
        bus.imm24In        = 24'($urandom());
        bus.destIn         = 4'($urandom());
        bus.src1In         = 4'($urandom());
        bus.src2In         = 4'($urandom());
        bus.carryIn        = 1'($urandom());
    endtask

    task automatic zeroInputs();
        bus.pcIn = '0;    bus.aluCmdIn = '0;  bus.memReadIn = 1'b0; bus.memWriteIn = 1'b0;
        bus.wbEnIn = 1'b0; bus.branchIn = 1'b0; bus.sIn = 1'b0;     bus.valRnIn = '0;
        bus.valRmIn = '0; bus.immIn = 1'b0;   bus.shiftOperandIn = '0; bus.imm24In = '0;
        bus.destIn = '0;  bus.src1In = '0;    bus.src2In = '0;      bus.carryIn = 1'b0;
    endtask

    // Predict the next edge from the currently driven inputs, then advance one cycle.
    task automatic tick();
        obs_t nxt;
        if (bus.freeze) begin
            nxt = model;
        end else if (bus.flush) begin
            nxt       = '0;
            nxt.count = (model.count == 16'hFFFF) ? model.count : model.count + 16'd1;
        end else begin
            nxt = inputsAsObs();
        end
        model = nxt;
        expQ.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst = 1'b1;
        bus.freeze = 1'b0; bus.flush = 1'b0;
        randomInputs();
        bus2.freeze = 1'b0; bus2.flush = 1'b0;
        bus2.pcIn = '0;    bus2.aluCmdIn = '0;  bus2.memReadIn = 1'b0; bus2.memWriteIn = 1'b0;
        bus2.wbEnIn = 1'b0; bus2.branchIn = 1'b0; bus2.sIn = 1'b0;     bus2.valRnIn = '0;
        bus2.valRmIn = '0; bus2.immIn = 1'b0;   bus2.shiftOperandIn = '0; bus2.imm24In = '0;
        bus2.destIn = '0;  bus2.src1In = '0;    bus2.src2In = '0;      bus2.carryIn = 1'b0;
        model = '0;
        expQ.push_back('0);
        #2;
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_initial: got=%h exp=%h", got, exp);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Load an entry, then assert reset mid-cycle and observe before the next edge.
        zeroInputs();
        bus.aluCmdIn = 4'h2; bus.wbEnIn = 1'b1; bus.pcIn = 32'h44; bus.destIn = 4'd7;
        tick();
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_preload: got=%h exp=%h", got, exp);
        end
        #3;
        rst = 1'b1;
        model = '0;
        expQ.push_back('0);
        #1;
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_async: got=%h exp=%h", got, exp);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // That edge loaded the still-driven inputs; re-synchronise the model with one more.
        model = inputsAsObs();
        got = sampleDut(); checks++;
        if (got !== model) begin
            failures++; $display("FAIL reset_release_load: got=%h exp=%h", got, model);
        end
    endtask

    task automatic test_load();
        obs_t got, exp;
        zeroInputs();
        bus.pcIn = 32'h10; bus.valRnIn = 32'hDEAD_BEEF; bus.destIn = 4'd3;
        bus.wbEnIn = 1'b1; bus.aluCmdIn = 4'h9;
        tick();
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL load_directed: got=%h exp=%h", got, exp);
        end
        checks++;
        if (bus.validOut !== 1'b1 || bus.valRnOut !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL load_fields: valid=%b valRn=%h exp valid=1 valRn=deadbeef",
                                 bus.validOut, bus.valRnOut);
        end
        for (int i = 0; i < 4; i++) begin
            randomInputs();
            tick();
            got = sampleDut(); exp = expQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL load_random[%0d]: got=%h exp=%h", i, got, exp);
            end
        end
        // Decode-side nulled instruction: zero control, still valid, not a bubble.
        randomInputs();
        bus.aluCmdIn = '0; bus.memReadIn = 1'b0; bus.memWriteIn = 1'b0;
        bus.wbEnIn = 1'b0; bus.branchIn = 1'b0; bus.sIn = 1'b0;
        tick();
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL load_nulled: got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_flush();
        obs_t got, exp;
        randomInputs();
        bus.memWriteIn = 1'b1; bus.src1In = 4'd5;
        tick();
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL flush_preload: got=%h exp=%h", got, exp);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL flush_bubble: got=%h exp=%h", got, exp);
        end
        checks++;
        if (bus.bubbleCount !== 16'd1 || bus.src1Out !== 4'd0 || bus.validOut !== 1'b0) begin
            failures++; $display("FAIL flush_count: count=%0d src1=%0d valid=%b exp 1 0 0",
                                 bus.bubbleCount, bus.src1Out, bus.validOut);
        end
    endtask

    task automatic test_freeze();
        obs_t got, exp;
        randomInputs();
        tick();
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL freeze_preload: got=%h exp=%h", got, exp);
        end
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomInputs();
            tick();
            got = sampleDut(); exp = expQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL freeze_hold[%0d]: got=%h exp=%h", i, got, exp);
            end
        end
        bus.freeze = 1'b0;
        randomInputs();
        tick();
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL freeze_release: got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_freeze_flush();
        obs_t got, exp;
        randomInputs();
        bus.freeze = 1'b1; bus.flush = 1'b1;
        tick();
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL freeze_flush_hold: got=%h exp=%h", got, exp);
        end
        bus.freeze = 1'b0;
        tick();
        bus.flush = 1'b0;
        got = sampleDut(); exp = expQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL freeze_flush_bubble: got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        for (int i = 0; i < 24; i++) begin
            randomInputs();
            bus.freeze = ($urandom_range(0, 3) == 0);
            bus.flush  = ($urandom_range(0, 2) == 0);
            tick();
            got = sampleDut(); exp = expQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL back_to_back[%0d]: got=%h exp=%h", i, got, exp);
            end
        end
        bus.freeze = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic test_saturation();
        obs_t got, exp;
        logic [1:0] sat;
        logic [1:0] satExp;
        sat = 2'd0;
        bus.freeze  = 1'b1;
        bus2.flush  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sat = (sat == 2'd3) ? sat : sat + 2'd1;
            satQ.push_back(sat);
            tick();
            satExp = satQ.pop_front(); checks++;
            if (bus2.bubbleCount !== satExp || bus2.validOut !== 1'b0) begin
                failures++; $display("FAIL saturate[%0d]: count=%0d valid=%b exp count=%0d valid=0",
                                     i, bus2.bubbleCount, bus2.validOut, satExp);
            end
            got = sampleDut(); exp = expQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL saturate_main_hold[%0d]: got=%h exp=%h", i, got, exp);
            end
        end
        bus2.flush = 1'b0;
        bus.freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_flush();
        test_freeze();
        test_freeze_flush();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regs_id_ex.md
Name: regs_id_ex

Overview:
Pipeline register between the decode stage and the execute stage of the 5-stage ARM-subset core. Captures decoded control, operand values and register indices each cycle. Supports freeze (hold) for memory stalls and flush (bubble insert) on a taken branch. Provides a valid flag and a saturating bubble counter for performance debug.

Parameters:
COUNT_W, 16, width of bubble counter bubbleCount

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
freeze  input  1  hold all registers (memory stall)
flush  input  1  taken branch resolved in EX; replace captured entry with bubble
pcIn  input  32  PC+4 from decode
aluCmdIn  input  4  ALU command
memReadIn  input  1  load control
memWriteIn  input  1  store control
wbEnIn  input  1  writeback enable
branchIn  input  1  branch control
sIn  input  1  update-status control
valRnIn  input  32  Rn operand value
valRmIn  input  32  Rm operand value
immIn  input  1  immediate-operand flag
shiftOperandIn  input  12  shifter operand field
imm24In  input  24  branch offset
destIn  input  4  destination register
src1In  input  4  source register 1 index
src2In  input  4  source register 2 index
carryIn  input  1  C flag from status register
pcOut, aluCmdOut, memReadOut, memWriteOut, wbEnOut, branchOut, sOut, valRnOut, valRmOut, immOut, shiftOperandOut, imm24Out, destOut, src1Out, src2Out, carryOut  output  widths as matching inputs  registered copies
validOut  output  1  entry holds a real (non-bubble) instruction
bubbleCount  output  COUNT_W  number of flush-inserted bubbles, saturating

Behaviour:
- Clock is clk; reset is asynchronous and active-high on rst.
- Reset: every output 0, including validOut and bubbleCount. Reset takes effect immediately, independent of clk, and overrides any in-flight capture.
- Priority per rising edge: rst > freeze > flush > load.
- freeze=1: all registers, validOut and bubbleCount hold. This applies even if flush=1 in the same cycle, because EX is also stalled and re-presents the branch.
- flush=1, freeze=0: control outputs cleared: aluCmdOut=0, memReadOut=0, memWriteOut=0, wbEnOut=0, branchOut=0, sOut=0, validOut=0.
  - Datapath fields (pc, vals, imm, shiftOperand, imm24, dest, src1, src2, carry) are also cleared to 0 so that the forwarding unit never matches on stale indices.
  - bubbleCount increments by 1 and saturates at 2^COUNT_W-1. No wrap.
- Load (freeze=0, flush=0): all outputs capture the corresponding inputs. validOut=1. bubbleCount holds.
- Decode-side nulling (condition fail or hazard) arrives as zero control on the inputs. It is still loaded with validOut=1 and does not count as a bubble.
- Latency: exactly 1 cycle input to output on load. No combinational path input to output.
- src1Out and src2Out are always registered, even when immOut=1. Hazard/forwarding logic qualifies their use.

Test Plan:
1. Assert rst mid-cycle with outputs loaded (aluCmdOut=4'h2, wbEnOut=1) -> all outputs 0 before the next clk edge; bubbleCount=0.
2. Load pcIn=32'h10, valRnIn=32'hDEAD_BEEF, destIn=4'd3, wbEnIn=1, aluCmdIn=4'h9 -> the next edge shows the same values and validOut=1.
3. flush=1 with loaded entry (memWriteIn=1, src1In=4'd5) -> next edge: all controls 0, src1Out=0, validOut=0, bubbleCount increments 0->1.
4. freeze=1 for 3 cycles while inputs toggle -> outputs and bubbleCount unchanged. Release with flush=0 -> new input captured on the first edge.
5. freeze=1 and flush=1 together -> no change to any output or bubbleCount. Next cycle flush=1, freeze=0 -> bubble inserted, count +1.
6. COUNT_W=2, apply 5 consecutive flushes -> bubbleCount sequence 1,2,3,3,3 (saturates, no wrap).
